// File: rtl/div_result_fifo.sv
// rtl/div_result_fifo.sv - result buffer for the sequential divider
// Captures every qr_valid strobe into a FIFO; overflowing results are dropped and counted.
module div_result_fifo #(
  parameter int NUM_LENGTH = 5,
  parameter int DEN_LENGTH = 3,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  qr_valid,
  input  logic [NUM_LENGTH-1:0] quo,
  input  logic [DEN_LENGTH-1:0] rem,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_LENGTH-1:0] out_quo,
  output logic [DEN_LENGTH-1:0] out_rem,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [7:0]            drop_cnt
);

  localparam int              EW      = NUM_LENGTH + DEN_LENGTH;
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          push, pop, drop;
  logic [EW-1:0] head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign out_valid = ~empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  assign pop  = out_valid & out_ready;
  assign push = qr_valid & (~full | pop);
  assign drop = qr_valid & full & ~pop;

  always_comb begin
    wp_d       = push ? wp_q + 1'b1 : wp_q;
    rp_d       = pop  ? rp_q + 1'b1 : rp_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    // A drop in the same cycle as a clear takes priority over the clear.
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr)                  drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately left unreset; the empty gating below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {quo, rem};
  end

  assign head    = mem_q[rp_q];
  assign out_quo = empty ? '0 : head[EW-1:DEN_LENGTH];
  assign out_rem = empty ? '0 : head[DEN_LENGTH-1:0];

endmodule

// File: tb/tb_div_result_fifo.sv
// tb/tb_div_result_fifo.sv - self-checking bench for div_result_fifo
// Directed vector table, hand-written corner sequences and a scoreboarded random run.
module tb_div_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       qr_valid, out_ready, ovf_clr;
  logic [4:0] quo, out_quo;
  logic [2:0] rem, out_rem;
  logic       out_valid, full, empty, overflow;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  int passed = 0;
  int total  = 0;

  div_result_fifo #(.NUM_LENGTH(5), .DEN_LENGTH(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .qr_valid(qr_valid), .quo(quo), .rem(rem),
    .out_valid(out_valid), .out_ready(out_ready), .out_quo(out_quo), .out_rem(out_rem),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       qv;
    logic [4:0] q;
    logic [2:0] r;
    logic       rdy;
    logic       clr;
    logic [2:0] e_cnt;
    logic [4:0] e_q;
    logic [2:0] e_r;
    logic       e_ovf;
    logic [7:0] e_drop;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic qv, input logic [4:0] q, input logic [2:0] r,
                              input logic rdy, input logic clr, input logic [2:0] ec,
                              input logic [4:0] eq, input logic [2:0] er,
                              input logic eo, input logic [7:0] ed);
    vec_t v;
    v.qv = qv; v.q = q; v.r = r; v.rdy = rdy; v.clr = clr;
    v.e_cnt = ec; v.e_q = eq; v.e_r = er; v.e_ovf = eo; v.e_drop = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    qr_valid = 1'b0; quo = '0; rem = '0; out_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"},    count, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " empty"},    empty, 1);
    check({tag, " full"},     full, 0);
    check({tag, " out_quo"},  out_quo, 0);
    check({tag, " out_rem"},  out_rem, 0);
    check({tag, " overflow"}, overflow, 0);
    check({tag, " drop_cnt"}, drop_cnt, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int         m_drops;
    logic       m_pop, m_push, m_full;
    logic [7:0] hd;

    // head values after each step, in order; full/empty/valid derive from e_cnt
    vecs[0]  = mk(1, 5'd5, 3'd1, 0, 0, 3'd1, 5'd5, 3'd1, 0, 8'd0);
    vecs[1]  = mk(1, 5'd6, 3'd0, 0, 0, 3'd2, 5'd5, 3'd1, 0, 8'd0);
    vecs[2]  = mk(1, 5'd3, 3'd2, 0, 0, 3'd3, 5'd5, 3'd1, 0, 8'd0);
    vecs[3]  = mk(1, 5'd7, 3'd3, 0, 0, 3'd4, 5'd5, 3'd1, 0, 8'd0);
    vecs[4]  = mk(1, 5'd1, 3'd1, 0, 0, 3'd4, 5'd5, 3'd1, 1, 8'd1);
    vecs[5]  = mk(1, 5'd2, 3'd2, 0, 0, 3'd4, 5'd5, 3'd1, 1, 8'd2);
    vecs[6]  = mk(1, 5'd4, 3'd3, 1, 0, 3'd4, 5'd6, 3'd0, 1, 8'd2);
    vecs[7]  = mk(0, 5'd0, 3'd0, 1, 0, 3'd3, 5'd3, 3'd2, 1, 8'd2);
    vecs[8]  = mk(0, 5'd0, 3'd0, 1, 0, 3'd2, 5'd7, 3'd3, 1, 8'd2);
    vecs[9]  = mk(0, 5'd0, 3'd0, 1, 0, 3'd1, 5'd4, 3'd3, 1, 8'd2);
    vecs[10] = mk(0, 5'd0, 3'd0, 1, 0, 3'd0, 5'd0, 3'd0, 1, 8'd2);
    vecs[11] = mk(0, 5'd0, 3'd0, 1, 0, 3'd0, 5'd0, 3'd0, 1, 8'd2);
    vecs[12] = mk(1, 5'd2, 3'd1, 1, 0, 3'd1, 5'd2, 3'd1, 1, 8'd2);
    vecs[13] = mk(0, 5'd0, 3'd0, 0, 1, 3'd1, 5'd2, 3'd1, 0, 8'd0);
    vecs[14] = mk(1, 5'd3, 3'd3, 0, 0, 3'd2, 5'd2, 3'd1, 0, 8'd0);
    vecs[15] = mk(1, 5'd1, 3'd2, 0, 0, 3'd3, 5'd2, 3'd1, 0, 8'd0);
    vecs[16] = mk(1, 5'd6, 3'd6, 0, 0, 3'd4, 5'd2, 3'd1, 0, 8'd0);
    vecs[17] = mk(1, 5'd5, 3'd5, 0, 1, 3'd4, 5'd2, 3'd1, 1, 8'd1);
    vecs[18] = mk(0, 5'd0, 3'd0, 0, 1, 3'd4, 5'd2, 3'd1, 0, 8'd0);

    do_reset();
    check_reset_state("reset");

    // single strobe, then asynchronous reset in mid-cycle
    qr_valid = 1'b1; quo = 5'd5; rem = 3'd1;
    step();
    idle_inputs();
    check("first count", count, 1);
    check("first out_valid", out_valid, 1);
    check("first out_quo", out_quo, 5);
    check("first out_rem", out_rem, 1);
    #2 rst = 1'b0;
    #1;
    check_reset_state("async reset");
    // strobe present in the cycle reset is released is captured
    @(negedge clk);
    qr_valid = 1'b1; quo = 5'd9; rem = 3'd4;
    rst = 1'b1;
    step();
    idle_inputs();
    check("post-reset capture count", count, 1);
    check("post-reset capture quo", out_quo, 9);
    check("post-reset capture rem", out_rem, 4);

    do_reset();
    for (int i = 0; i < 19; i++) begin
      qr_valid = vecs[i].qv; quo = vecs[i].q; rem = vecs[i].r;
      out_ready = vecs[i].rdy; ovf_clr = vecs[i].clr;
      step();
      check($sformatf("vec%0d count", i),     count,     vecs[i].e_cnt);
      check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_cnt != 0);
      check($sformatf("vec%0d full", i),      full,      vecs[i].e_cnt == 4);
      check($sformatf("vec%0d empty", i),     empty,     vecs[i].e_cnt == 0);
      check($sformatf("vec%0d out_quo", i),   out_quo,   vecs[i].e_q);
      check($sformatf("vec%0d out_rem", i),   out_rem,   vecs[i].e_r);
      check($sformatf("vec%0d overflow", i),  overflow,  vecs[i].e_ovf);
      check($sformatf("vec%0d drop_cnt", i),  drop_cnt,  vecs[i].e_drop);
    end
    idle_inputs();

    // FIFO is full here: 300 drops saturate the counter
    qr_valid = 1'b1; quo = 5'd31; rem = 3'd7;
    for (int i = 0; i < 300; i++) step();
    idle_inputs();
    check("sat drop_cnt", drop_cnt, 255);
    check("sat overflow", overflow, 1);
    check("sat count", count, 4);
    check("sat head quo", out_quo, 2);
    check("sat head rem", out_rem, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("sat clear drop_cnt", drop_cnt, 0);
    check("sat clear overflow", overflow, 0);

    // random traffic against a scoreboard queue
    do_reset();
    m_drops = 0;
    for (int c = 0; c < 1200; c++) begin
      qr_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      quo       = 5'($urandom);
      rem       = 3'($urandom);
      m_full = (exp_q.size() == 4);
      m_pop  = (exp_q.size() > 0) && out_ready;
      m_push = qr_valid && (!m_full || m_pop);
      if (m_pop) begin
        hd = exp_q.pop_front();
        check($sformatf("rnd%0d pop data", c), {out_quo, out_rem}, hd);
      end
      if (m_push) exp_q.push_back({quo, rem});
      if (qr_valid && m_full && !m_pop && m_drops < 255) m_drops++;
      step();
      check($sformatf("rnd%0d count", c), count, exp_q.size());
      check($sformatf("rnd%0d drop_cnt", c), drop_cnt, m_drops);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_result_fifo.md
# div_result_fifo

Buffers quotient/remainder results from the sequential divider for a downstream consumer that may stall. The divider's result port has no back-pressure: `qr_valid` is a one-cycle strobe, so every result must be captured that cycle. This block captures each strobe into a small FIFO and re-presents results on a valid/ready interface. Results that arrive while the FIFO is full are dropped and counted.

## Interface
- `NUM_LENGTH`, default 5: quotient width; must match the divider instance.
- `DEN_LENGTH`, default 3: remainder width; must match the divider instance.
- `DEPTH`, default 4: entry count; power of two, at least 2. `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `qr_valid`  in  1  divider result strobe.
- `quo`  in  NUM_LENGTH  divider quotient, sampled when `qr_valid` is 1.
- `rem`  in  DEN_LENGTH  divider remainder, sampled when `qr_valid` is 1.
- `out_valid`  out  1  head entry is available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_quo`  out  NUM_LENGTH  head quotient.
- `out_rem`  out  DEN_LENGTH  head remainder.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky flag: at least one result has been dropped.
- `ovf_clr`  in  1  synchronous clear of `overflow` and `drop_cnt`.
- `drop_cnt`  out  8  number of dropped results, saturating at 255.

## Operation
- Storage is a `DEPTH`-entry array of `{quo, rem}` with write pointer `wp`, read pointer `rp` (both AW bits, natural wrap) and a `count` register.
- Pop: `pop = out_valid & out_ready`.
- Push: `push = qr_valid & (~full | pop)`.
  - A push while full is legal only when a pop happens in the same cycle.
  - In that case `count` is unchanged and both pointers advance.
- Drop: `drop = qr_valid & full & ~pop`.
  - Storage and pointers are unchanged.
  - `overflow` is set to 1.
  - `drop_cnt` increments, saturating at 255.
- `ovf_clr`:
  - Next cycle, `overflow` becomes 0 and `drop_cnt` becomes 0.
  - If a drop occurs in the same cycle, the drop wins: `overflow` becomes 1 and `drop_cnt` becomes 1.
- `count` update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Empty FIFO: `out_valid` is 0, so no pop is possible and `out_ready` is ignored. A push on an empty FIFO is not fall-through.
- Output data:
  - `out_quo`/`out_rem` equal `mem[rp]` while `out_valid` is 1.
  - They are forced to 0 while empty, so no X-propagation from unreset storage.
- Ordering is strict FIFO. No entry is ever duplicated or reordered.
- Status outputs:
  - `full`, `empty` and `out_valid` are decoded from registered `count`.
  - `out_valid = ~empty`.
  - No combinational path from `qr_valid` to any output.
- Reset (`rst` = 0, asynchronous):
  - `wp`, `rp`, `count` become 0.
  - `empty` = 1, `full` = 0, `out_valid` = 0.
  - `out_quo` = 0, `out_rem` = 0.
  - `overflow` = 0, `drop_cnt` = 0.
  - Storage contents are not reset.
- Reset in mid-operation discards all buffered entries immediately. A `qr_valid` in the cycle `rst` deasserts is captured normally.

## Timing
- Capture latency: a result strobed at edge N is visible (`out_valid` = 1, data valid) after edge N, i.e. in cycle N+1.
- Throughput:
  - One push and one pop per cycle.
  - Back-to-back `qr_valid` strobes are all captured while `count < DEPTH`.
- Handshake: the consumer samples `out_quo`/`out_rem` at the edge where `out_valid & out_ready`. The next entry appears in the following cycle.
- `out_valid` never drops without a pop. Data stays stable while `out_valid` = 1 and `out_ready` = 0.
- `drop_cnt` and `overflow` update on the edge following the dropping strobe.

## Test plan
- Reset, then one strobe (`quo`=5, `rem`=1) with `out_ready`=0 → next cycle `out_valid`=1, `out_quo`=5, `out_rem`=1, `count`=1. Assert `rst`=0 mid-cycle → all outputs return to reset values immediately.
- `DEPTH`=4, `out_ready`=0, strobes (5,1),(6,0),(3,2),(7,3) → `full`=1, `count`=4. Then `out_ready`=1 for 4 cycles → pops in that exact order, then `empty`=1 and `out_quo`=0.
- Full FIFO with `out_ready`=0, two strobes (1,1),(2,2) → both dropped, `overflow`=1, `drop_cnt`=2, contents unchanged.
- Full FIFO, `out_ready`=1 and strobe (4,3) in the same cycle → head popped, (4,3) written at tail, `count` stays 4, `drop_cnt` unchanged.
- `ovf_clr`=1 in the same cycle as a drop → `overflow`=1, `drop_cnt`=1. Then `ovf_clr`=1 alone → both 0. Also force 300 drops → `drop_cnt` saturates at 255.
- Random traffic: `qr_valid` and `out_ready` each about 50 %, ≥1000 cycles, checked against a scoreboard queue → popped sequence equals the pushed sequence minus drops, and `count` matches the model every cycle.
